// File: rtl/fire_pkg.sv
// Shared definitions for the fire4 drain-side blocks: word geometry, writer
// state encoding and the RAM address-width helper.
package fire_pkg;

    localparam int WIDTH  = 16;
    localparam int DSP_NO = 128;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } writer_state_t;

    // One RAM word per channel per pixel, channel-planar.
    function automatic int calc_addr_w(input int dsp_no, input int wout);
        return $clog2(dsp_no * wout * wout);
    endfunction

endpackage

// File: rtl/ofm_shift_bank.sv
// Shadow copy of one pixel's output words; loads in parallel, then shifts
// toward element 0 so the writer only ever reads a single fixed slot.
module ofm_shift_bank #(
    parameter int DSP_NO = fire_pkg::DSP_NO,
    parameter int WIDTH  = fire_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din [0:DSP_NO-1],
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] bank_q [0:DSP_NO-1];
    logic [WIDTH-1:0] bank_d [0:DSP_NO-1];

    always_comb begin
        for (int i = 0; i < DSP_NO; i++) begin
            bank_d[i] = bank_q[i];
        end
        if (load) begin
            for (int i = 0; i < DSP_NO; i++) begin
                bank_d[i] = din[i];
            end
        end else if (shift) begin
            for (int i = 0; i < DSP_NO - 1; i++) begin
                bank_d[i] = bank_q[i+1];
            end
            bank_d[DSP_NO-1] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DSP_NO; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DSP_NO; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign dout = bank_q[0];

endmodule

// File: rtl/fire4_expand3_ofm_writer.sv
// Serialises each captured fire4_expand3 pixel into the channel-planar output
// RAM, one word per cycle, and reports drain activity and layer completion.
module fire4_expand3_ofm_writer #(
    parameter int DSP_NO = fire_pkg::DSP_NO,
    parameter int WIDTH  = fire_pkg::WIDTH,
    parameter int WOUT   = 32,
    parameter int ADDR_W = fire_pkg::calc_addr_w(DSP_NO, WOUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              layer_start,
    input  logic              fire4_expand3_sample,
    input  logic [WIDTH-1:0]  ofm [0:DSP_NO-1],
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_wdata,
    output logic              ram_feedback,
    output logic              layer_done,
    output logic              overrun
);

    import fire_pkg::*;

    localparam int PIX_NUM = WOUT * WOUT;
    localparam int PIX_W   = $clog2(PIX_NUM) + 1;
    localparam int CH_W    = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

    writer_state_t     state_q, state_d;
    logic [PIX_W-1:0]  pixel_q, pixel_d, pixel_inc;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              bank_load, bank_shift;

    ofm_shift_bank #(
        .DSP_NO (DSP_NO),
        .WIDTH  (WIDTH)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .load  (bank_load),
        .shift (bank_shift),
        .din   (ofm),
        .dout  (ram_wdata)
    );

    assign pixel_inc = pixel_q + 1'b1;

    // Address steps by one channel plane per write, so addr = ch*WOUT^2 + pixel.
    always_comb begin
        state_d    = state_q;
        pixel_d    = pixel_q;
        ch_d       = ch_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        done_d     = done_q;
        overrun_d  = overrun_q;
        bank_load  = 1'b0;
        bank_shift = 1'b0;

        if (layer_start) begin
            state_d   = IDLE;
            pixel_d   = '0;
            done_d    = 1'b0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire4_expand3_sample) begin
                        bank_load = 1'b1;
                        ch_d      = '0;
                        addr_d    = ADDR_W'(pixel_q);
                        we_d      = 1'b1;
                        state_d   = DRAIN;
                    end
                end
                DRAIN: begin
                    bank_shift = 1'b1;
                    if (fire4_expand3_sample) begin
                        overrun_d = 1'b1;
                    end
                    if (ch_q == CH_W'(DSP_NO - 1)) begin
                        pixel_d = pixel_inc;
                        if (pixel_inc == PIX_W'(PIX_NUM)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        we_d   = 1'b1;
                        ch_d   = ch_q + 1'b1;
                        addr_d = addr_q + ADDR_W'(PIX_NUM);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pixel_q   <= '0;
            ch_q      <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pixel_q   <= pixel_d;
            ch_q      <= ch_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign ram_we       = we_q;
    assign ram_feedback = we_q;
    assign ram_addr     = addr_q;
    assign layer_done   = done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_fire4_expand3_ofm_writer.sv
// Directed bench: a default-size writer for drain/overrun/reset behaviour and a
// WOUT=2, DSP_NO=4 writer for layer completion and layer_start handling.
module tb_fire4_expand3_ofm_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ls_b, smp_b, ls_s, smp_s;
    logic [15:0] ofm_b [0:127];
    logic [15:0] ofm_s [0:3];
    logic [15:0] exp_b [0:127];
    logic [15:0] exp_s [0:3];

    logic        we_b, fb_b, done_b, ovr_b;
    logic [16:0] addr_b;
    logic [15:0] data_b;
    logic        we_s, fb_s, done_s, ovr_s;
    logic [3:0]  addr_s;
    logic [15:0] data_s;

    int n_cmp = 0;
    int n_err = 0;

    fire4_expand3_ofm_writer dut_big (
        .clk                  (clk),
        .rst                  (rst),
        .layer_start          (ls_b),
        .fire4_expand3_sample (smp_b),
        .ofm                  (ofm_b),
        .ram_we               (we_b),
        .ram_addr             (addr_b),
        .ram_wdata            (data_b),
        .ram_feedback         (fb_b),
        .layer_done           (done_b),
        .overrun              (ovr_b)
    );

    fire4_expand3_ofm_writer #(
        .DSP_NO (4),
        .WIDTH  (16),
        .WOUT   (2)
    ) dut_small (
        .clk                  (clk),
        .rst                  (rst),
        .layer_start          (ls_s),
        .fire4_expand3_sample (smp_s),
        .ofm                  (ofm_s),
        .ram_we               (we_s),
        .ram_addr             (addr_s),
        .ram_wdata            (data_s),
        .ram_feedback         (fb_s),
        .layer_done           (done_s),
        .overrun              (ovr_s)
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One-cycle sample pulse (optionally with layer_start); returns at the
    // negedge of the cycle that follows the capturing edge.
    task automatic applyStimulus(input bit sm, input bit with_start);
        @(negedge clk);
        if (sm) begin
            smp_s = 1'b1;
            ls_s  = with_start;
        end else begin
            smp_b = 1'b1;
            ls_b  = with_start;
        end
        @(negedge clk);
        smp_s = 1'b0;
        ls_s  = 1'b0;
        smp_b = 1'b0;
        ls_b  = 1'b0;
    endtask

    // Walks a whole drain, one write per cycle; optionally fires an
    // overrunning sample (with garbage data) at channel ovr_at.
    task automatic checkDrain(input bit sm, input int pix, input int ovr_at, input string tag);
        int          n;
        int          stride;
        logic        a_we, a_fb;
        logic [31:0] a_addr, a_data, e_data;
        n      = sm ? 4 : 128;
        stride = sm ? 4 : 1024;
        for (int ch = 0; ch < n; ch++) begin
            if (sm) begin
                a_we = we_s; a_fb = fb_s; a_addr = 32'(addr_s); a_data = 32'(data_s);
                e_data = 32'(exp_s[ch]);
            end else begin
                a_we = we_b; a_fb = fb_b; a_addr = 32'(addr_b); a_data = 32'(data_b);
                e_data = 32'(exp_b[ch]);
            end
            checkOutput($sformatf("%s we ch%0d", tag, ch), 32'(a_we), 32'd1);
            checkOutput($sformatf("%s feedback ch%0d", tag, ch), 32'(a_fb), 32'd1);
            checkOutput($sformatf("%s addr ch%0d", tag, ch), a_addr, 32'(ch * stride + pix));
            checkOutput($sformatf("%s data ch%0d", tag, ch), a_data, e_data);
            if (ch == ovr_at) begin
                if (sm) begin
                    smp_s = 1'b1;
                    for (int i = 0; i < 4; i++) ofm_s[i] = 16'hDEAD;
                end else begin
                    smp_b = 1'b1;
                    for (int i = 0; i < 128; i++) ofm_b[i] = 16'hDEAD;
                end
            end
            @(negedge clk);
            smp_s = 1'b0;
            smp_b = 1'b0;
        end
        checkOutput($sformatf("%s we after", tag), 32'(sm ? we_s : we_b), 32'd0);
        checkOutput($sformatf("%s feedback after", tag), 32'(sm ? fb_s : fb_b), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " we_b"},   32'(we_b),   32'd0);
        checkOutput({tag, " addr_b"}, 32'(addr_b), 32'd0);
        checkOutput({tag, " data_b"}, 32'(data_b), 32'd0);
        checkOutput({tag, " fb_b"},   32'(fb_b),   32'd0);
        checkOutput({tag, " done_b"}, 32'(done_b), 32'd0);
        checkOutput({tag, " ovr_b"},  32'(ovr_b),  32'd0);
        checkOutput({tag, " we_s"},   32'(we_s),   32'd0);
        checkOutput({tag, " done_s"}, 32'(done_s), 32'd0);
        checkOutput({tag, " ovr_s"},  32'(ovr_s),  32'd0);
    endtask

    initial begin
        rst = 1'b0;
        ls_b = 1'b0; smp_b = 1'b0; ls_s = 1'b0; smp_s = 1'b0;
        for (int i = 0; i < 128; i++) ofm_b[i] = '0;
        for (int i = 0; i < 4; i++) ofm_s[i] = '0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b1;
        @(negedge clk);
        checkResetState("post-reset idle");

        // Pixel 0, ofm[i] = i+1
        for (int i = 0; i < 128; i++) begin
            ofm_b[i] = 16'(i + 1);
            exp_b[i] = 16'(i + 1);
        end
        applyStimulus(0, 0);
        checkDrain(0, 0, -1, "pix0");
        checkOutput("pix0 overrun", 32'(ovr_b), 32'd0);

        // Pixel 1, ofm[i] = 0x8000 | i
        for (int i = 0; i < 128; i++) begin
            ofm_b[i] = 16'h8000 | 16'(i);
            exp_b[i] = 16'h8000 | 16'(i);
        end
        applyStimulus(0, 0);
        checkDrain(0, 1, -1, "pix1");

        // Pixel 2 with an overrunning sample 50 cycles into the drain
        for (int i = 0; i < 128; i++) begin
            ofm_b[i] = 16'h4000 + 16'(i * 3);
            exp_b[i] = 16'h4000 + 16'(i * 3);
        end
        applyStimulus(0, 0);
        checkDrain(0, 2, 49, "pix2 ovr");
        checkOutput("pix2 overrun set", 32'(ovr_b), 32'd1);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("pix2 no extra write %0d", k), 32'(we_b), 32'd0);
            @(negedge clk);
        end
        checkOutput("overrun sticky", 32'(ovr_b), 32'd1);

        // Pixel 3, reset asserted during the 40th write
        for (int i = 0; i < 128; i++) ofm_b[i] = 16'h7000 + 16'(i);
        applyStimulus(0, 0);
        repeat (39) @(negedge clk);
        checkOutput("40th write we", 32'(we_b), 32'd1);
        checkOutput("40th write addr", 32'(addr_b), 32'(39 * 1024 + 3));
        rst = 1'b0;
        #1;
        checkResetState("mid-drain reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 128; i++) begin
            ofm_b[i] = 16'h1234 ^ 16'(i);
            exp_b[i] = 16'h1234 ^ 16'(i);
        end
        applyStimulus(0, 0);
        checkDrain(0, 0, -1, "after reset pix0");

        // Small writer: whole layer of 4 pixels
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 4; i++) begin
                ofm_s[i] = 16'h0A00 + 16'(p * 16 + i);
                exp_s[i] = 16'h0A00 + 16'(p * 16 + i);
            end
            applyStimulus(1, 0);
            checkDrain(1, p, (p == 3) ? 2 : -1, $sformatf("small pix%0d", p));
            checkOutput($sformatf("small done after pix%0d", p), 32'(done_s), (p == 3) ? 32'd1 : 32'd0);
        end
        checkOutput("small overrun set", 32'(ovr_s), 32'd1);

        // Fifth sample in DONE is ignored
        applyStimulus(1, 0);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("done ignores sample %0d", k), 32'(we_s), 32'd0);
            @(negedge clk);
        end
        checkOutput("done held", 32'(done_s), 32'd1);

        // layer_start coincident with a sample: sample dropped, flags cleared
        applyStimulus(1, 1);
        checkOutput("start drops sample we", 32'(we_s), 32'd0);
        checkOutput("start clears done", 32'(done_s), 32'd0);
        checkOutput("start clears overrun", 32'(ovr_s), 32'd0);
        @(negedge clk);
        checkOutput("start drops sample we later", 32'(we_s), 32'd0);
        for (int i = 0; i < 4; i++) begin
            ofm_s[i] = 16'h5500 + 16'(i);
            exp_s[i] = 16'h5500 + 16'(i);
        end
        applyStimulus(1, 0);
        checkDrain(1, 0, -1, "new layer pix0");
        checkOutput("new layer done", 32'(done_s), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fire4_expand3_ofm_writer.md
# fire4_expand3_ofm_writer

Drain side of the fire4_expand3 interface. Captures the DSP_NO parallel output words that fire4_expand3 presents on each `fire4_expand3_sample` pulse and serializes them, one word per cycle, into the layer's single-port output RAM in channel-planar order. It drives `ram_feedback` back to the producer and flags layer completion after WOUT² pixels.

## Interface
- `DSP_NO`, 128: output channels per pixel (parallel words per sample)
- `WIDTH`, 16: word width
- `WOUT`, 32: output feature-map side; WOUT² pixels per layer
- `ADDR_W`, $clog2(DSP_NO*WOUT**2): RAM address width (17 at defaults)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, asynchronous, active-low
- `layer_start`  in  1  single-cycle pulse; clears the pixel counter and flags, arms the block
- `fire4_expand3_sample`  in  1  producer pulse; `ofm` is valid in the same cycle
- `ofm`  in  WIDTH x [0:DSP_NO-1]  producer outputs, post-ReLU
- `ram_we`  out  1  write strobe
- `ram_addr`  out  ADDR_W  write address
- `ram_wdata`  out  WIDTH  write data
- `ram_feedback`  out  1  high while a drain is in progress
- `layer_done`  out  1  level; all WOUT² pixels written
- `overrun`  out  1  sticky; a sample arrived during a drain

## Operation
- States:
  - IDLE: armed, waiting for a sample.
  - DRAIN: serializing the captured bank.
  - DONE: layer complete.
- Reset: all outputs 0, state IDLE, pixel counter 0.
- IDLE, on `fire4_expand3_sample`:
  - Capture all DSP_NO `ofm` words into the shadow shift bank.
  - Load the channel counter with 0 and the write address with the pixel index.
  - Go to DRAIN.
- DRAIN, one write per cycle:
  - `ram_wdata` = bank[0]; the bank shifts toward index 0.
  - `ram_addr` advances by WOUT² each cycle, so addr = ch*WOUT² + pixel. Use an incremental adder, not a multiplier.
  - After the write of channel DSP_NO-1: increment the pixel counter. If it reaches WOUT², go to DONE; otherwise go to IDLE.
- DONE:
  - `layer_done` = 1.
  - Samples are ignored silently.
  - Stay in DONE until `layer_start`.
- `fire4_expand3_sample` during DRAIN:
  - Ignore the sample; the bank is not disturbed.
  - Set `overrun`. It is cleared only by reset or `layer_start`.
- `layer_start`, in any state:
  - Go to IDLE, pixel counter 0, clear `layer_done` and `overrun`.
  - Abort any drain in progress; `ram_we` is 0 from the next cycle.
  - Has priority over a simultaneous sample; that sample is dropped.
- Pixel counter width: $clog2(WOUT**2)+1. The layer ends on an exact compare with WOUT².

## Timing
- Sample at edge cycle t:
  - `ram_we` is high for cycles t+1 .. t+DSP_NO, with channel 0 at t+1.
  - `ram_feedback` is high for exactly the same cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Back-to-back samples are legal from cycle t+DSP_NO+1 onward (IDLE is re-entered at t+DSP_NO+1). With the producer's period of 9*CHIN+1 = 289 cycles this gives 161 cycles of slack.
- The producer computes finish = !ram_feedback && sample, so `ram_feedback` must be low in every cycle in which a sample is legal.
- `layer_done` rises in the cycle after the last write of pixel WOUT²-1.

## Structure
- Shared package `fire_pkg`:
  - WIDTH and DSP_NO constants.
  - `writer_state_t` enum {IDLE, DRAIN, DONE}.
  - The shared ADDR_W computation.
- Sub-module `ofm_shift_bank`:
  - DSP_NO x WIDTH with parallel load and shift-by-one.
  - Outputs element 0.
  - Avoids a DSP_NO:1 read mux.
- Control FSM, counters and address adder stay in the top.

## Test plan
1. Reset mid-drain: assert `rst` at the 40th write → all outputs 0 immediately; after release, a sample drains normally starting at pixel 0.
2. Single sample, defaults: `ofm[i]` = i+1, pixel 0 → 128 writes, addr = i*1024, data = i+1; `ram_feedback` high for exactly 128 cycles; `overrun` = 0.
3. Second pixel: sample with `ofm[i]` = 16'h8000|i → addr = i*1024+1.
4. Overrun: sample 50 cycles into a drain → `overrun` = 1; the drain continues with the original data; no extra writes.
5. Layer end with WOUT=2, DSP_NO=4:
   - 4 samples → 16 writes at addrs {0,4,8,12}+p.
   - `layer_done` = 1 one cycle after the last write.
   - A 5th sample produces no write.
6. `layer_start` coincident with a sample in DONE → sample dropped, `layer_done` = 0, `overrun` = 0; the next sample writes pixel 0.
